// File: rtl/subleq_uart_tx_mmio_if.sv
// Memory-bus bundle between the subleq core (master) and the UART TX responder (slave).
interface subleq_uart_tx_mmio_if;
  logic [12:0] iAddress;
  logic [31:0] iData;
  logic        iWren;
  logic [31:0] oQ;
  logic        oSel;

  modport master (output iAddress, iData, iWren, input oQ, oSel);
  modport slave  (input iAddress, iData, iWren, output oQ, oSel);
endinterface

// File: rtl/subleq_uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter for the subleq core: TX FIFO fed by writes,
// pollable STATUS word, registered read data muxed beside RAM via oSel.
module subleq_uart_tx_mmio #(
  parameter logic [12:0] BASE         = 13'h1FFC,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 4,
  parameter bit          NEGATE_TX    = 1'b1
) (
  input  logic                  iClock,
  input  logic                  iReset,
  subleq_uart_tx_mmio_if.slave  bus,
  output logic                  oTx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            sel_q;

  logic            hit, rd_status, push_req, push_ok, pop;
  logic            full, empty, busy, bit_end;
  logic [1:0]      off;
  logic [7:0]      tx_byte, neg_byte;
  logic [31:0]     status;
  logic            unused_data;

  assign hit       = bus.iAddress[12:2] == BASE[12:2];
  assign off       = bus.iAddress[1:0];
  assign rd_status = hit && (off == 2'd1);
  assign push_req  = hit && (off == 2'd0) && bus.iWren;

  // Only the low byte of -data matters, and it depends only on the low byte of data.
  assign neg_byte    = ~bus.iData[7:0] + 8'd1;
  assign tx_byte     = NEGATE_TX ? neg_byte : bus.iData[7:0];
  assign unused_data = ^bus.iData[31:8];

  assign full    = cnt_q == CW'(FIFO_DEPTH);
  assign empty   = cnt_q == '0;
  assign busy    = state_q != IDLE;
  assign bit_end = baud_q == BW'(CLKS_PER_BIT - 1);
  assign pop     = (state_q == IDLE) && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok = push_req && (!full || pop);
  assign cnt_d   = cnt_q + CW'(push_ok) - CW'(pop);

  assign status  = {23'd0, 5'(cnt_q), ovf_q, empty, full, busy};
  assign rdata_d = rd_status ? status : 32'd0;
  // An overflowing push wins over the read-clear in the same cycle.
  assign ovf_d   = (push_req && !push_ok) ? 1'b1 : (rd_status ? 1'b0 : ovf_q);

  always_ff @(posedge iClock) begin
    if (iReset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!empty)                    state_d = START;
      START: if (bit_end)                   state_d = DATA;
      DATA:  if (bit_end && bit_q == 3'd7)  state_d = STOP;
      STOP:  if (bit_end)                   state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  always_comb begin
    oTx = 1'b1;
    case (state_q)
      START:   oTx = 1'b0;
      DATA:    oTx = sh_q[0];
      default: oTx = 1'b1;
    endcase
  end

  always_comb begin
    baud_d = (state_q == IDLE || bit_end) ? '0 : baud_q + BW'(1);
    bit_d  = bit_q;
    sh_d   = sh_q;
    if (pop) begin
      sh_d  = mem_q[rptr_q];
      bit_d = 3'd0;
    end else if (state_q == DATA && bit_end) begin
      sh_d  = {1'b0, sh_q[7:1]};
      bit_d = bit_q + 3'd1;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
      sel_q   <= 1'b0;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
      sel_q   <= hit;
      if (push_ok) wptr_q <= wptr_q + PW'(1);
      if (pop)     rptr_q <= rptr_q + PW'(1);
    end
  end

  always_ff @(posedge iClock) begin
    if (push_ok) mem_q[wptr_q] <= tx_byte;
  end

  assign bus.oQ   = rdata_q;
  assign bus.oSel = sel_q;
endmodule

// File: tb/tb_subleq_uart_tx_mmio.sv
// Randomised + directed bench for subleq_uart_tx_mmio against a frame-timeline model.
module tb_subleq_uart_tx_mmio;
  localparam logic [12:0] BASE = 13'h1FFC;
  localparam int C = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  subleq_uart_tx_mmio_if bus();

  subleq_uart_tx_mmio #(.BASE(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(D), .NEGATE_TX(1'b1)) u_dut (
    .iClock(clk), .iReset(rst), .bus(bus), .oTx(tx));

  always #5 clk = ~clk;

  int vectors = 0, errors = 0, timeouts = 0;
  bit chk_en = 0, done = 0;
  bit pin_q_en = 0, pin_sel_en = 0, pin_tx_en = 0;
  logic [31:0] pin_q;
  logic pin_sel, pin_tx;

  // Model: queue of pending bytes and the cycle offset into the frame on the wire.
  byte unsigned mq[$];
  int           ft = -1;
  logic [7:0]   fbyte = 8'h00;
  bit           movf = 0;
  logic [31:0]  eq = 32'd0;
  bit           esel = 0;
  bit           m_hit, m_set;
  logic [1:0]   m_off;
  logic [31:0]  m_neg, m_stat;

  function automatic logic [31:0] mstatus();
    return {23'd0, 5'(mq.size()), movf, mq.size() == 0, mq.size() == D, ft >= 0};
  endfunction

  function automatic logic mtx();
    int idx;
    if (ft < 0) return 1'b1;
    idx = ft / C;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return fbyte[idx-1];
  endfunction

  always @(posedge clk) begin
    m_hit = bus.iAddress[12:2] == BASE[12:2];
    m_off = bus.iAddress[1:0];
    if (rst) begin
      mq.delete(); ft = -1; movf = 0; eq = 32'd0; esel = 0;
    end else begin
      m_stat = mstatus();
      esel = m_hit;
      eq = (m_hit && m_off == 2'd1) ? m_stat : 32'd0;
      if (ft >= 0) begin
        ft = ft + 1;
        if (ft == 10 * C) ft = -1;
      end else if (mq.size() > 0) begin
        fbyte = mq.pop_front();
        ft = 0;
      end
      m_set = 0;
      if (m_hit && m_off == 2'd0 && bus.iWren) begin
        m_neg = 32'd0 - bus.iData;
        if (mq.size() < D) mq.push_back(m_neg[7:0]);
        else m_set = 1;
      end
      if (m_set) movf = 1;
      else if (m_hit && m_off == 2'd1) movf = 0;
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", n, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("oQ", bus.oQ, eq);
      chk("oSel", {31'd0, bus.oSel}, {31'd0, esel});
      chk("oTx", {31'd0, tx}, {31'd0, mtx()});
      if (pin_q_en)   chk("pin_oQ", bus.oQ, pin_q);
      if (pin_sel_en) chk("pin_oSel", {31'd0, bus.oSel}, {31'd0, pin_sel});
      if (pin_tx_en)  chk("pin_oTx", {31'd0, tx}, {31'd0, pin_tx});
    end
    if (done) begin
      chk("timeouts", timeouts, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
    end
  end

  task automatic step();
    @(posedge clk); #1;
    pin_q_en = 0; pin_sel_en = 0; pin_tx_en = 0;
  endtask

  task automatic drive(input logic [12:0] a, input logic [31:0] d, input logic w);
    bus.iAddress = a; bus.iData = d; bus.iWren = w;
  endtask

  task automatic pq(input logic [31:0] v);
    pin_q_en = 1; pin_q = v;
  endtask

  task automatic ptx(input logic v);
    pin_tx_en = 1; pin_tx = v;
  endtask

  task automatic psel(input logic v);
    pin_sel_en = 1; pin_sel = v;
  endtask

  task automatic wait_model(input bit want_full, input int limit);
    int n = 0;
    while (!(ft < 0 && mq.size() == (want_full ? D : 0)) && n < limit) begin
      step(); n++;
    end
    if (n >= limit) timeouts++;
  endtask

  logic [9:0]  fb;
  logic [12:0] ra;
  int          r;

  initial begin
    drive(13'h0100, 32'd0, 1'b0);
    rst = 1;
    repeat (3) step();
    chk_en = 1; ptx(1'b1); pq(32'd0); psel(1'b0);
    rst = 0;
    repeat (20) step();
    ptx(1'b1);

    drive(BASE + 13'd1, 32'd0, 1'b0);
    step(); pq(32'h0000_0004); psel(1'b1);

    // 0xFFFFFFBF negated is 0x41 on the wire.
    drive(BASE, 32'hFFFF_FFBF, 1'b1);
    step();
    drive(BASE + 13'd1, 32'd0, 1'b0);
    fb = {1'b1, 8'h41, 1'b0};
    for (int k = 0; k < 40; k++) begin
      step(); ptx(fb[k/4]);
      if (k == 20) pq(32'h0000_0005);
    end
    step(); step(); pq(32'h0000_0004);

    drive(BASE, $urandom, 1'b1); step();
    drive(13'h0100, 32'd0, 1'b0); step();
    for (int i = 0; i < 5; i++) begin
      drive(BASE, $urandom, 1'b1); step();
    end
    drive(BASE + 13'd1, 32'd0, 1'b0);
    step(); pq(32'h0000_004B);
    step(); pq(32'h0000_0043);
    drive(13'h0100, 32'd0, 1'b0);

    wait_model(1'b1, 200);
    drive(BASE, $urandom, 1'b1); step();
    drive(BASE + 13'd1, 32'd0, 1'b0);
    step(); pq(32'h0000_0043);
    drive(13'h0100, 32'd0, 1'b0);
    wait_model(1'b0, 400);
    step(); ptx(1'b1);

    drive(BASE - 13'd1, 32'h1234, 1'b1);
    step(); pq(32'd0); psel(1'b0);
    drive(BASE + 13'd4, 32'h5678, 1'b1);
    step(); pq(32'd0); psel(1'b0);
    drive(BASE + 13'd1, 32'd0, 1'b0);
    step(); pq(32'h0000_0004); psel(1'b1);
    step(); ptx(1'b1);

    drive(BASE, $urandom, 1'b1); step();
    drive(13'h0100, 32'd0, 1'b0);
    r = 0;
    while (ft != 4 * C + 1 && r < 100) begin step(); r++; end
    if (r >= 100) timeouts++;
    rst = 1;
    step(); ptx(1'b1); pq(32'd0); psel(1'b0);
    rst = 0;
    drive(BASE + 13'd1, 32'd0, 1'b0);
    step(); pq(32'h0000_0004);
    drive(13'h0100, 32'd0, 1'b0);
    repeat (50) step();
    ptx(1'b1);

    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(99));
      ra = (r < 70) ? (BASE - 13'd1 + 13'($urandom_range(5))) : 13'($urandom);
      drive(ra, $urandom, ($urandom_range(2) == 0));
      rst = ($urandom_range(1499) == 0);
      step();
    end
    rst = 0;
    drive(13'h0100, 32'd0, 1'b0);
    wait_model(1'b0, 600);
    repeat (5) step();
    done = 1;
    step();
  end
endmodule
